// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment scanner: time-slices NDIG digits with a dead cycle per slot,
// optional hex glyphs, leading-zero blanking and per-digit blinking.
module sevenseg_scan #(
  parameter int unsigned NDIG        = 4,
  parameter int unsigned DIV         = 50000,
  parameter int unsigned BLINK_SCANS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  input  logic              hex_en,
  input  logic              blank_lz,
  input  logic [NDIG-1:0]   blink_mask,
  output logic [6:0]        segments,
  output logic [NDIG-1:0]   an
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [DW-1:0] DivLast   = DW'(DIV - 1);
  localparam logic [IW-1:0] IdxLast   = IW'(NDIG - 1);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_SCANS - 1);

  logic [4*NDIG-1:0] disp_q;
  logic              hex_q;
  logic              lz_q;
  logic [NDIG-1:0]   mask_q;
  logic [DW-1:0]     div_cnt;
  logic [IW-1:0]     idx;
  logic [BW-1:0]     blink_cnt;
  logic              blink_ph;

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q    <= '0;
      hex_q     <= 1'b0;
      lz_q      <= 1'b0;
      mask_q    <= '0;
      div_cnt   <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      if (load) begin
        disp_q <= value;
        hex_q  <= hex_en;
        lz_q   <= blank_lz;
        mask_q <= blink_mask;
      end
      if (div_cnt == DivLast) begin
        div_cnt <= '0;
        if (idx == IdxLast) begin
          idx <= '0;
          // One blink count per complete scan of all digits.
          if (blink_cnt == BlinkLast) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end else begin
          idx <= idx + IW'(1);
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  logic [3:0]      nib;
  logic [6:0]      glyph;
  logic [NDIG-1:0] lz_vec;
  logic            run_zero;

  // lz_vec[i] is set when nibbles i..NDIG-1 are all zero.
  always_comb begin
    lz_vec   = '0;
    run_zero = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      run_zero  = run_zero & (disp_q[4*i +: 4] == 4'h0);
      lz_vec[i] = run_zero;
    end
  end

  always_comb begin
    nib = disp_q[{idx, 2'b00} +: 4];
    unique case (nib)
      4'h0:    glyph = 7'b0000001;
      4'h1:    glyph = 7'b1001111;
      4'h2:    glyph = 7'b0010010;
      4'h3:    glyph = 7'b0000110;
      4'h4:    glyph = 7'b1001100;
      4'h5:    glyph = 7'b0100100;
      4'h6:    glyph = 7'b0100000;
      4'h7:    glyph = 7'b0001111;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0001100;
      4'hA:    glyph = hex_q ? 7'b0001000 : 7'b1111111;
      4'hB:    glyph = hex_q ? 7'b1100000 : 7'b1111111;
      4'hC:    glyph = hex_q ? 7'b0110001 : 7'b1111111;
      4'hD:    glyph = hex_q ? 7'b1000010 : 7'b1111111;
      4'hE:    glyph = hex_q ? 7'b0110000 : 7'b1111111;
      default: glyph = hex_q ? 7'b0111000 : 7'b1111111;
    endcase
  end

  always_comb begin
    an       = '1;
    segments = 7'b1111111;
    // Slot cycle 0 is dark so the previous digit's segments never ghost onto the next.
    if (div_cnt != '0) begin
      an[idx] = 1'b0;
      if (blink_ph && mask_q[idx]) begin
        segments = 7'b1111111;
      end else if (lz_q && (idx != '0) && lz_vec[idx]) begin
        segments = 7'b1111111;
      end else begin
        segments = glyph;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: directed scenarios plus randomized loads, checked against a
// time-based reference model (slot and blink phase derived from cycles since reset).
module tb_sevenseg_scan;

  localparam int NDIG = 4;
  localparam int DIV  = 4;
  localparam int BS   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic        hex_en;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [6:0]  segments;
  logic [3:0]  an;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_t;
  logic [15:0] m_disp;
  logic        m_hex;
  logic        m_lz;
  logic [3:0]  m_mask;

  sevenseg_scan #(
    .NDIG(NDIG),
    .DIV(DIV),
    .BLINK_SCANS(BS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .value(value),
    .hex_en(hex_en),
    .blank_lz(blank_lz),
    .blink_mask(blink_mask),
    .segments(segments),
    .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph_of(input int n, input logic hx);
    case (n)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0001100;
      10: return hx ? 7'b0001000 : 7'b1111111;
      11: return hx ? 7'b1100000 : 7'b1111111;
      12: return hx ? 7'b0110001 : 7'b1111111;
      13: return hx ? 7'b1000010 : 7'b1111111;
      14: return hx ? 7'b0110000 : 7'b1111111;
      default: return hx ? 7'b0111000 : 7'b1111111;
    endcase
  endfunction

  function automatic int m_slot();
    return m_t % DIV;
  endfunction

  function automatic int m_digit();
    return (m_t / DIV) % NDIG;
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] a;
    a = 4'b1111;
    if (m_slot() != 0) a[m_digit()] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] exp_seg();
    int d;
    int nibv;
    int upper;
    int ph;
    if (m_slot() == 0) return 7'b1111111;
    d     = m_digit();
    ph    = (m_t / (DIV * NDIG * BS)) % 2;
    nibv  = (int'(m_disp) >> (4 * d)) & 15;
    upper = int'(m_disp) >> (4 * d);
    if (ph == 1 && m_mask[d]) return 7'b1111111;
    if (m_lz && d != 0 && upper == 0) return 7'b1111111;
    return glyph_of(nibv, m_hex);
  endfunction

  // Advance one clock; the model absorbs the inputs present at the edge.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_t = 0;
      m_disp = '0;
      m_hex = 1'b0;
      m_lz = 1'b0;
      m_mask = '0;
    end else begin
      m_t++;
      if (load) begin
        m_disp = value;
        m_hex = hex_en;
        m_lz = blank_lz;
        m_mask = blink_mask;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v, input logic hx, input logic lz,
                         input logic [3:0] mk);
    load = 1'b1;
    value = v;
    hex_en = hx;
    blank_lz = lz;
    blink_mask = mk;
    step();
    load = 1'b0;
    value = $urandom;
  endtask

  // Advance until mid-slot (slot cycle 2) of digit d; bounded.
  task automatic goto_digit(input int d);
    int n;
    n = 0;
    step();
    while (!(m_digit() == d && m_slot() == 2) && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) begin
      failures++;
      $display("FAIL goto_digit%0d: slot never reached", d);
    end
  endtask

  task automatic test_reset();
    load = 1'b1;
    value = 16'h9999;
    reset = 1'b1;
    step();
    reset = 1'b0;
    load = 1'b0;
    checks++;
    if (an !== 4'b1111) begin
      failures++;
      $display("FAIL reset_an: got %b want 1111", an);
    end
    checks++;
    if (segments !== 7'b1111111) begin
      failures++;
      $display("FAIL reset_seg: got %b want 1111111", segments);
    end
  endtask

  task automatic test_scan_sequence();
    logic [3:0] ea;
    logic [6:0] es;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c == 0 || c == 4) begin
        ea = 4'b1111;
        es = 7'b1111111;
      end else if (c < 4) begin
        ea = 4'b1110;
        es = 7'b0000001;
      end else begin
        ea = 4'b1101;
        es = 7'b0000001;
      end
      checks++;
      if (an !== ea || segments !== es) begin
        failures++;
        $display("FAIL scan_cycle%0d: got an=%b seg=%b want an=%b seg=%b", c, an, segments, ea,
                 es);
      end
      step();
    end
  endtask

  task automatic test_digits();
    do_load(16'h1234, 1'b0, 1'b0, 4'b0000);
    goto_digit(0);
    checks++;
    if (an !== 4'b1110 || segments !== 7'b1001100) begin
      failures++;
      $display("FAIL digit0_1234: got an=%b seg=%b want an=1110 seg=1001100", an, segments);
    end
    goto_digit(1);
    checks++;
    if (an !== 4'b1101 || segments !== 7'b0000110) begin
      failures++;
      $display("FAIL digit1_1234: got an=%b seg=%b want an=1101 seg=0000110", an, segments);
    end
    goto_digit(3);
    checks++;
    if (an !== 4'b0111 || segments !== 7'b1001111) begin
      failures++;
      $display("FAIL digit3_1234: got an=%b seg=%b want an=0111 seg=1001111", an, segments);
    end
  endtask

  task automatic test_hex_lz();
    logic [6:0] want_hex [4];
    want_hex[0] = 7'b0111000;
    want_hex[1] = 7'b0001000;
    want_hex[2] = 7'b1111111;
    want_hex[3] = 7'b1111111;
    do_load(16'h00AF, 1'b1, 1'b1, 4'b0000);
    for (int d = 0; d < 4; d++) begin
      goto_digit(d);
      checks++;
      if (segments !== want_hex[d]) begin
        failures++;
        $display("FAIL hex_lz_digit%0d: got %b want %b", d, segments, want_hex[d]);
      end
    end
    do_load(16'h00AF, 1'b0, 1'b1, 4'b0000);
    for (int d = 0; d < 2; d++) begin
      goto_digit(d);
      checks++;
      if (segments !== 7'b1111111) begin
        failures++;
        $display("FAIL nohex_digit%0d: got %b want 1111111", d, segments);
      end
    end
  endtask

  task automatic test_zero_lz();
    logic [6:0] want;
    do_load(16'h0000, 1'b0, 1'b1, 4'b0000);
    for (int d = 0; d < 4; d++) begin
      goto_digit(d);
      want = (d == 0) ? 7'b0000001 : 7'b1111111;
      checks++;
      if (segments !== want) begin
        failures++;
        $display("FAIL zero_lz_digit%0d: got %b want %b", d, segments, want);
      end
    end
  endtask

  task automatic test_blink();
    logic [6:0] want;
    reset = 1'b1;
    step();
    reset = 1'b0;
    // Load on the edge that leaves reset so the pattern is visible from cycle 1.
    do_load(16'h8888, 1'b0, 1'b0, 4'b0001);
    for (int c = 1; c <= 70; c++) begin
      if (m_slot() != 0 && m_digit() == 0) begin
        want = (c < 32 || c >= 64) ? 7'b0000000 : 7'b1111111;
        checks++;
        if (segments !== want) begin
          failures++;
          $display("FAIL blink_digit0_c%0d: got %b want %b", c, segments, want);
        end
      end else if (m_slot() != 0 && m_digit() == 1) begin
        checks++;
        if (segments !== 7'b0000000) begin
          failures++;
          $display("FAIL blink_digit1_c%0d: got %b want 0000000", c, segments);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid_scan();
    do_load(16'h5678, 1'b0, 1'b0, 4'b0000);
    goto_digit(2);
    reset = 1'b1;
    load = 1'b1;
    value = 16'h1111;
    step();
    reset = 1'b0;
    load = 1'b0;
    checks++;
    if (an !== 4'b1111 || segments !== 7'b1111111) begin
      failures++;
      $display("FAIL midreset_dead: got an=%b seg=%b want an=1111 seg=1111111", an, segments);
    end
    step();
    checks++;
    if (an !== 4'b1110 || segments !== 7'b0000001) begin
      failures++;
      $display("FAIL midreset_digit0: got an=%b seg=%b want an=1110 seg=0000001", an, segments);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      load = ($urandom_range(0, 7) == 0);
      v = 16'($urandom);
      // Bias toward leading zeros so blanking is exercised.
      case ($urandom_range(0, 3))
        0: v = v & 16'h000F;
        1: v = v & 16'h00FF;
        2: v = v & 16'h0FFF;
        default: ;
      endcase
      value = v;
      hex_en = 1'($urandom);
      blank_lz = 1'($urandom);
      blink_mask = 4'($urandom);
      step();
      checks++;
      if (an !== exp_an() || segments !== exp_seg()) begin
        failures++;
        $display("FAIL random_t%0d: got an=%b seg=%b want an=%b seg=%b", m_t, an, segments,
                 exp_an(), exp_seg());
      end
    end
    reset = 1'b0;
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    load = 1'b0;
    value = '0;
    hex_en = 1'b0;
    blank_lz = 1'b0;
    blink_mask = '0;
    m_t = 0;
    m_disp = '0;
    m_hex = 1'b0;
    m_lz = 1'b0;
    m_mask = '0;
    test_reset();
    test_scan_sequence();
    test_digits();
    test_hex_lz();
    test_zero_lz();
    test_blink();
    test_reset_mid_scan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 SHALL have parameter NDIG, default 4, meaning the number of multiplexed digits (1..8).
REQ-002 SHALL have parameter DIV, default 50000, meaning clock cycles per digit slot (>=2).
REQ-003 SHALL have parameter BLINK_SCANS, default 64, meaning full scans per blink half-period (>=1).
REQ-004 SHALL use one clock and a synchronous, active-high reset; the clock and reset ports are named clk and reset.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-006 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port load, input, 1 bit: when high, captures value, hex_en, blank_lz and blink_mask.
REQ-008 SHALL have port value, input, 4*NDIG bits: one nibble per digit; digit 0 = value[3:0] = least significant.
REQ-009 SHALL have port hex_en, input, 1 bit: 1 shows glyphs A-F for nibbles 10-15; 0 blanks those nibbles.
REQ-010 SHALL have port blank_lz, input, 1 bit: enables leading-zero blanking.
REQ-011 SHALL have port blink_mask, input, NDIG bits: a set bit makes that digit blink.
REQ-012 SHALL have port segments, output, 7 bits: active-low, bit6=a ... bit0=g.
REQ-013 SHALL have port an, output, NDIG bits: active-low digit enables, at most one bit low.

Function
REQ-014 SHALL hold registered state: disp_q, hex_q, lz_q, mask_q, div_cnt (0..DIV-1), idx (0..NDIG-1), blink_cnt (0..BLINK_SCANS-1) and blink_ph.
REQ-015 SHALL, when load=1, update disp_q, hex_q, lz_q and mask_q on that clock edge; the new content SHALL be visible on outputs from the next cycle, with scan counters unaffected.
REQ-016 SHALL increment div_cnt every cycle; at DIV-1 it SHALL wrap to 0 and idx SHALL advance, wrapping NDIG-1 -> 0.
REQ-017 SHALL, when idx wraps to 0, advance blink_cnt; when blink_cnt wraps from BLINK_SCANS-1 to 0, blink_ph SHALL toggle.
REQ-018 SHALL drive an and segments combinationally from registered state only, with no dependency on inputs in the same cycle.
REQ-019 SHALL drive an=all 1s and segments=7'b1111111 while div_cnt==0 (anti-ghosting dead cycle).
REQ-020 SHALL, while div_cnt!=0, drive an[idx]=0 with all other an bits 1.
REQ-021 SHALL decode digit glyphs as 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100.
REQ-022 SHALL, with hex_q=1, decode A=0001000, b=1100000, C=0110001, d=1000010, E=0110000 and F=0111000; with hex_q=0, nibbles 10-15 SHALL give 1111111.
REQ-023 SHALL blank digit i (segments=1111111, an still asserted) when lz_q=1, i!=0, and nibbles i..NDIG-1 of disp_q are all zero; digit 0 SHALL never be leading-zero blanked.
REQ-024 SHALL blank digit i when blink_ph=1 and mask_q[i]=1.
REQ-025 SHALL apply blanking with priority dead cycle > blink > leading-zero > glyph decode.

Reset
REQ-026 SHALL, when reset=1, clear every state register of REQ-014 to 0 on the clock edge, so that outputs next cycle are an=all 1s and segments=1111111.
REQ-027 SHALL give reset priority over a simultaneous load.
REQ-028 SHALL, after reset, show digit 0 as "0" (0000001) from div_cnt=1, since disp_q=0 and lz_q=0.

Verification (NDIG=4, DIV=4, BLINK_SCANS=2)
REQ-029 SHALL cover: reset released -> cycle 0: an=1111, segments=1111111; cycles 1-3: an=1110, segments=0000001; cycle 4: dead cycle; cycles 5-7: an=1101.
REQ-030 SHALL cover: load value=0x1234, hex_en=0 -> digit0 slot: an=1110, segments=1001100; digit1: an=1101, segments=0000110; digit3: an=0111, segments=1001111.
REQ-031 SHALL cover: load 0x00AF, hex_en=1, blank_lz=1 -> digit0=0111000, digit1=0001000, digits 2-3=1111111; reload with hex_en=0 -> digits 0-1=1111111.
REQ-032 SHALL cover: load 0x0000, blank_lz=1 -> digit0=0000001, digits 1-3=1111111.
REQ-033 SHALL cover: load 0x8888, blink_mask=0001 -> digit0=0000000 for the first 32 cycles, then 1111111 for the next 32 cycles, with digit1 steady at 0000000 throughout.
REQ-034 SHALL cover: reset asserted mid-scan (idx=2) together with load=1, value=0x1111 -> next cycle an=1111; then digit0 shows 0000001 (load discarded).
